led_fill_drain_ctrl: RTL and testbench
======================================

// Module: led_fill_drain_ctrl
// PURPOSE
//  Sequencer for the 8-bit LED serial-in/parallel-out shift register in the
//  "fill then drain, left to right" effect. Divides the board clock into step
//  ticks, then drives serial data, a one-cycle shift-enable strobe and a clear
//  pulse, so that LEDs light one by one, hold, go dark one by one, pause, repeat.
//  Sits between the board clock/switch inputs and the shifter's s_in/enable.
// PARAMETERS
//  WIDTH       8           number of LEDs / shifter stages (>=2)
//  DIV         25_000_000  clk cycles per step tick (>=1)
//  HOLD_STEPS  4           ticks spent all-lit between fill and drain (>=1)
//  PAUSE_STEPS 4           ticks spent all-dark before the next fill (>=1)
// PORTS
//  clk        in   1                 system clock, all logic on rising edge
//  reset      in   1                 synchronous, active-high
//  en         in   1                 run enable (switch); low = stop and clear
//  s_out      out  1                 serial data for shifter s_in
//  step       out  1                 one-cycle shift strobe (shifter enable)
//  clr        out  1                 one-cycle shifter clear request
//  lit_count  out  $clog2(WIDTH+1)   number of 1s currently in shifter
//  phase      out  2                 0 IDLE,1 FILL/HOLD... see encoding below
//  cycle_done out  1                 one-cycle pulse at end of each PAUSE
// BEHAVIOUR
//  Reset (sync, high) and only reset: state IDLE, prescaler=0, s_out=0,
//   step=0, clr=0, lit_count=0, cycle_done=0, hold/pause counter=0.
//  All outputs registered. phase: 0 IDLE, 1 FILL, 2 HOLD, 3 DRAIN; PAUSE
//   reports phase=0 with lit_count=0 (internal state distinct from IDLE).
//  Prescaler: counts 0..DIV-1 only outside IDLE; tick when count==DIV-1,
//   then wraps to 0. DIV=1 -> tick every cycle. Prescaler cleared in IDLE.
//  IDLE: en=1 -> FILL next cycle, prescaler starts at 0; first tick occurs
//   DIV cycles after entering FILL.
//  FILL: on tick -> step=1, s_out=1, lit_count+1 (registered, same edge).
//   When the incremented value equals WIDTH -> HOLD.
//  HOLD: no step; counts HOLD_STEPS ticks, on the last -> DRAIN.
//  DRAIN: on tick -> step=1, s_out=0, lit_count-1; reaching 0 -> PAUSE.
//  PAUSE: no step; counts PAUSE_STEPS ticks; on last tick -> FILL and
//   cycle_done=1 for that one cycle.
//  step high exactly one cycle per tick in FILL/DRAIN; s_out valid while
//   step=1 and holds last value otherwise. Zero steps in HOLD/PAUSE/IDLE.
//  Full cycle = 2*WIDTH+HOLD_STEPS+PAUSE_STEPS ticks.
//  en falling in any non-IDLE state: next cycle -> IDLE, clr=1 for one
//   cycle, lit_count=0, step=0, s_out=0, counters cleared; a tick coinciding
//   with en=0 is discarded (no step). en toggling in IDLE with clr pending:
//   clr still pulses once.
//  lit_count never exceeds WIDTH nor underflows 0 (saturating guards).
//  reset mid-operation: takes priority over en and tick; no clr pulse.
// TESTING (WIDTH=8, DIV=4, HOLD_STEPS=2, PAUSE_STEPS=2)
//  reset 3 cycles, en=0 -> all outputs 0, phase=0, no step for 50 cycles.
//  en=1 from IDLE -> first step 4 cycles after FILL entry; 8 steps, s_out=1,
//   spaced 4 cycles; lit_count 1..8; phase 1 then 2 after 8th step.
//  continue -> 2 ticks (8 cycles) no step in HOLD, then 8 steps s_out=0,
//   lit_count 7..0, then 8 idle cycles, cycle_done pulse; period 80 cycles.
//  model shifter from step/s_out -> pattern 0x80,0xC0..0xFF, then
//   0x7F,0x3F..0x00 each cycle; repeat 3 cycles identical.
//  en=0 at lit_count=5 (mid-FILL, same cycle as a tick) -> no step, clr=1
//   one cycle, lit_count=0, phase=0; en=1 again restarts FILL from 0.
//  reset asserted mid-DRAIN -> next cycle all outputs 0, clr=0; DIV=1 build
//   -> step every cycle during FILL, 8 consecutive strobes.

Source files
------------

// File: rtl/led_fill_drain_ctrl.sv
// Fill-then-drain LED sequencer: prescaled step ticks drive s_out/step/clr for an 8-stage SIPO shifter.
// All outputs registered (one cycle after the tick/enable decision); no backpressure, en low aborts to IDLE.
module led_fill_drain_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DIV         = 25_000_000,
    parameter int HOLD_STEPS  = 4,
    parameter int PAUSE_STEPS = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         en_i,
    output logic                         s_out_o,
    output logic                         step_o,
    output logic                         clr_o,
    output logic [$clog2(WIDTH+1)-1:0]   lit_count_o,
    output logic [1:0]                   phase_o,
    output logic                         cycle_done_o
);

    localparam int CW     = $clog2(WIDTH + 1);
    localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SEGMAX = (HOLD_STEPS > PAUSE_STEPS) ? HOLD_STEPS : PAUSE_STEPS;
    localparam int SW     = (SEGMAX > 1) ? $clog2(SEGMAX) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] LIT_FULL   = CW'(WIDTH);
    localparam logic [CW-1:0] LIT_LAST   = CW'(WIDTH - 1);
    localparam logic [SW-1:0] HOLD_LAST  = SW'(HOLD_STEPS - 1);
    localparam logic [SW-1:0] PAUSE_LAST = SW'(PAUSE_STEPS - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_HOLD, S_DRAIN, S_PAUSE} state_t;

    state_t          state_q;
    logic [PW-1:0]   presc_q;
    logic [SW-1:0]   seg_q;
    logic [CW-1:0]   lit_q;
    logic [1:0]      phase_q;
    logic            s_out_q;
    logic            step_q;
    logic            clr_q;
    logic            done_q;
    logic            tick;

    assign tick = (state_q != S_IDLE) && (presc_q == PRESC_LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            seg_q   <= '0;
            lit_q   <= '0;
            phase_q <= 2'd0;
            s_out_q <= 1'b0;
            step_q  <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            // Abort wins over any tick landing in the same cycle.
            if (state_q != S_IDLE && !en_i) begin
                state_q <= S_IDLE;
                presc_q <= '0;
                seg_q   <= '0;
                lit_q   <= '0;
                phase_q <= 2'd0;
                s_out_q <= 1'b0;
                clr_q   <= 1'b1;
            end else begin
                if (state_q == S_IDLE) presc_q <= '0;
                else                   presc_q <= tick ? '0 : presc_q + 1'b1;
                case (state_q)
                    S_IDLE: begin
                        if (en_i) begin
                            state_q <= S_FILL;
                            phase_q <= 2'd1;
                        end
                    end
                    S_FILL: begin
                        if (tick && lit_q != LIT_FULL) begin
                            step_q  <= 1'b1;
                            s_out_q <= 1'b1;
                            lit_q   <= lit_q + 1'b1;
                            if (lit_q == LIT_LAST) begin
                                state_q <= S_HOLD;
                                phase_q <= 2'd2;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (tick) begin
                            if (seg_q == HOLD_LAST) begin
                                seg_q   <= '0;
                                state_q <= S_DRAIN;
                                phase_q <= 2'd3;
                            end else begin
                                seg_q <= seg_q + 1'b1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (tick && lit_q != '0) begin
                            step_q  <= 1'b1;
                            s_out_q <= 1'b0;
                            lit_q   <= lit_q - 1'b1;
                            if (lit_q == CW'(1)) begin
                                state_q <= S_PAUSE;
                                phase_q <= 2'd0;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (tick) begin
                            if (seg_q == PAUSE_LAST) begin
                                seg_q   <= '0;
                                state_q <= S_FILL;
                                phase_q <= 2'd1;
                                done_q  <= 1'b1;
                            end else begin
                                seg_q <= seg_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        phase_q <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign s_out_o      = s_out_q;
    assign step_o       = step_q;
    assign clr_o        = clr_q;
    assign lit_count_o  = lit_q;
    assign phase_o      = phase_q;
    assign cycle_done_o = done_q;

endmodule

// File: tb/tb_led_fill_drain_ctrl.sv
// Randomized + directed bench for led_fill_drain_ctrl (DIV=4 and DIV=1 instances on shared stimulus).
module tb_led_fill_drain_ctrl;
    localparam int W = 8;
    localparam int H = 2;
    localparam int P = 2;
    localparam int N = 2 * W + H + P;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;

    logic       s4, st4, cl4, dn4;
    logic [3:0] lit4;
    logic [1:0] ph4;
    logic       s1, st1, cl1, dn1;
    logic [3:0] lit1;
    logic [1:0] ph1;

    always #5 clk = ~clk;

    led_fill_drain_ctrl #(.WIDTH(W), .DIV(4), .HOLD_STEPS(H), .PAUSE_STEPS(P)) dut (
        .clk_i(clk), .reset_i(reset), .en_i(en),
        .s_out_o(s4), .step_o(st4), .clr_o(cl4),
        .lit_count_o(lit4), .phase_o(ph4), .cycle_done_o(dn4)
    );

    led_fill_drain_ctrl #(.WIDTH(W), .DIV(1), .HOLD_STEPS(H), .PAUSE_STEPS(P)) dut1 (
        .clk_i(clk), .reset_i(reset), .en_i(en),
        .s_out_o(s1), .step_o(st1), .clr_o(cl1),
        .lit_count_o(lit1), .phase_o(ph1), .cycle_done_o(dn1)
    );

    int         vectors = 0;
    int         miscompares = 0;
    bit         chk_en = 1'b0;
    bit         rec = 1'b0;
    bit         run_m = 1'b0;
    bit         clr_m = 1'b0;
    int         c_m = 0;
    logic [7:0] sh = 8'h00;
    logic [10:0] mask1 = '0;
    int         q_off[$];
    int         q_done[$];
    logic [7:0] q_sh[$];
    logic [7:0] pat [16];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick_n();
        @(negedge clk);
        #1;
    endtask

    // Run tracker: cycles since the first FILL cycle of the current run.
    always @(posedge clk) begin
        if (reset) begin
            run_m = 1'b0; clr_m = 1'b0; c_m = 0;
        end else if (run_m && !en) begin
            run_m = 1'b0; clr_m = 1'b1;
        end else if (!run_m && en) begin
            run_m = 1'b1; c_m = 0; clr_m = 1'b0;
        end else begin
            if (run_m) c_m++;
            clr_m = 1'b0;
        end
    end

    // Expected outputs from tick arithmetic: tick j lands at offset j*div.
    function automatic void model(input int div, output int e_step, output int e_sout,
                                  output int e_clr, output int e_done,
                                  output int e_lit, output int e_ph);
        int j, jj, ti;
        e_step = 0; e_sout = 0; e_clr = clr_m ? 1 : 0; e_done = 0; e_lit = 0; e_ph = 0;
        if (run_m) begin
            e_clr = 0;
            j  = c_m / div;
            jj = j % N;
            if (jj < W)              begin e_ph = 1; e_lit = jj; end
            else if (jj < W + H)     begin e_ph = 2; e_lit = W; end
            else if (jj < 2 * W + H) begin e_ph = 3; e_lit = W - (jj - W - H); end
            e_sout = (jj >= 1 && jj <= W + H) ? 1 : 0;
            if (c_m > 0 && c_m % div == 0) begin
                ti = (j - 1) % N;
                e_step = (ti < W || (ti >= W + H && ti < 2 * W + H)) ? 1 : 0;
                e_done = (ti == N - 1) ? 1 : 0;
            end
        end
    endfunction

    always @(negedge clk) begin : cmp
        int es, eo, ec, ed, el, ep, esh;
        if (chk_en) begin
            model(4, es, eo, ec, ed, el, ep);
            chk("d4.step", int'(st4), es);
            chk("d4.s_out", int'(s4), eo);
            chk("d4.clr", int'(cl4), ec);
            chk("d4.cycle_done", int'(dn4), ed);
            chk("d4.lit_count", int'(lit4), el);
            chk("d4.phase", int'(ph4), ep);
            if (!run_m)   sh = 8'h00;
            else if (st4) sh = {s4, sh[7:1]};
            if (run_m) begin
                esh = (ep == 1 || ep == 2) ? ((255 << (8 - el)) & 255) : ((1 << el) - 1);
                chk("d4.shifter", int'(sh), esh);
            end
            if (rec && run_m && st4) begin
                q_off.push_back(c_m);
                q_sh.push_back(sh);
            end
            if (rec && run_m && dn4) q_done.push_back(c_m);

            model(1, es, eo, ec, ed, el, ep);
            chk("d1.step", int'(st1), es);
            chk("d1.s_out", int'(s1), eo);
            chk("d1.clr", int'(cl1), ec);
            chk("d1.cycle_done", int'(dn1), ed);
            chk("d1.lit_count", int'(lit1), el);
            chk("d1.phase", int'(ph1), ep);
            if (rec && run_m && c_m <= 10 && st1) mask1[c_m] = 1'b1;
        end
    end

    initial begin
        int stepcnt, cnt, exp_off;
        pat = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
        reset = 1'b1;
        en    = 1'b0;
        repeat (3) tick_n();
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("reset.step", int'(st4), 0);
        chk("reset.s_out", int'(s4), 0);
        chk("reset.clr", int'(cl4), 0);
        chk("reset.lit_count", int'(lit4), 0);
        chk("reset.phase", int'(ph4), 0);
        chk("reset.cycle_done", int'(dn4), 0);

        stepcnt = 0;
        repeat (50) begin
            tick_n();
            stepcnt += int'(st4) + int'(st1) + int'(cl4) + int'(lit4);
        end
        chk("idle.activity", stepcnt, 0);

        // Three uninterrupted periods from IDLE.
        rec = 1'b1;
        en  = 1'b1;
        cnt = 0;
        while (q_done.size() < 3 && cnt < 400) begin
            tick_n();
            cnt++;
        end
        rec = 1'b0;
        chk("periods.cycle_done_count", q_done.size(), 3);
        chk("periods.step_count", q_off.size(), 48);
        if (q_off.size() == 48) begin
            for (int p = 0; p < 3; p++) begin
                for (int k = 0; k < 16; k++) begin
                    exp_off = (k < 8) ? 4 * (k + 1) : 4 * (k + 3);
                    chk("periods.step_offset", q_off[16 * p + k], exp_off + 80 * p);
                    chk("periods.shifter_pattern", int'(q_sh[16 * p + k]), int'(pat[k]));
                end
            end
        end
        if (q_done.size() == 3) begin
            for (int p = 0; p < 3; p++) chk("periods.cycle_done_offset", q_done[p], 80 * (p + 1));
        end
        chk("div1.consecutive_strobes", int'(mask1), 'h1FE);

        // Drop en on the cycle the sixth fill tick fires.
        cnt = 0;
        while (int'(lit4) != 5 && cnt < 200) begin
            tick_n();
            cnt++;
        end
        chk("drop.reached_lit5", int'(lit4), 5);
        chk("drop.phase_fill", int'(ph4), 1);
        repeat (3) tick_n();
        en = 1'b0;
        tick_n();
        chk("drop.step", int'(st4), 0);
        chk("drop.clr", int'(cl4), 1);
        chk("drop.lit_count", int'(lit4), 0);
        chk("drop.phase", int'(ph4), 0);
        tick_n();
        chk("drop.clr_once", int'(cl4), 0);
        en = 1'b1;
        tick_n();
        repeat (4) tick_n();
        chk("restart.step", int'(st4), 1);
        chk("restart.lit_count", int'(lit4), 1);
        chk("restart.phase", int'(ph4), 1);

        // Reset in the middle of DRAIN.
        cnt = 0;
        while (ph4 != 2'd3 && cnt < 200) begin
            tick_n();
            cnt++;
        end
        chk("drain.reached", int'(ph4), 3);
        repeat (5) tick_n();
        reset = 1'b1;
        tick_n();
        chk("rst_drain.step", int'(st4), 0);
        chk("rst_drain.s_out", int'(s4), 0);
        chk("rst_drain.clr", int'(cl4), 0);
        chk("rst_drain.lit_count", int'(lit4), 0);
        chk("rst_drain.phase", int'(ph4), 0);
        chk("rst_drain.cycle_done", int'(dn4), 0);
        reset = 1'b0;

        repeat (4000) begin
            tick_n();
            if ($urandom_range(0, 99) == 0) en = ~en;
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
        tick_n();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
